branch_flush_ctrl: RTL
======================

Name: branch_flush_ctrl

Overview:
Parametrised branch/jump resolution unit for the filter processor pipeline. It decodes conditional-branch (compare-flag qualified) and unconditional-jump opcodes at the resolve stage and drives the PC target select. It squashes the FLUSH_DEPTH younger instructions by holding NOP-insert strobes for a counted number of unstalled cycles. It also gates the PC enable during pipeline stalls and exposes a busy flag to the hazard logic.

Parameters:
OPCODE_W, 4, opcode field width.
BR_OPCODE, 4'b1110, conditional branch; taken when cmp_flag_i=1.
JMP_OPCODE, 4'b1111, unconditional jump; always taken.
FLUSH_DEPTH, 2, number of younger instructions squashed per taken branch; legal range 1..15.
CNT_W, $clog2(FLUSH_DEPTH+1), width of the flush counter (derived; not overridden).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
valid_i  in  1  resolve-stage instruction is valid.
opcode_i  in  OPCODE_W  resolve-stage opcode.
cmp_flag_i  in  1  compare flag from the ALU/compare unit.
stall_i  in  1  pipeline stall from the hazard unit.
pc_sel_o  out  1  1 = load branch target into the PC.
pc_hold_o  out  1  1 = PC not updated this cycle (active-high disable).
nop_f_o  out  1  insert NOP into the fetch/decode register.
nop_d_o  out  1  insert NOP into the decode/execute register.
busy_o  out  1  flush in progress.

Behaviour:
- taken = valid_i & ~stall_i & ((opcode_i==BR_OPCODE & cmp_flag_i) | opcode_i==JMP_OPCODE).
- FSM states: IDLE and FLUSH. Flush counter cnt is CNT_W bits wide.
- IDLE:
  - pc_sel_o = taken (combinational, same cycle as resolve).
  - nop_f_o = nop_d_o = taken.
  - If taken and FLUSH_DEPTH>1: next state FLUSH, cnt <= FLUSH_DEPTH-1.
  - If taken and FLUSH_DEPTH==1: stay in IDLE.
- FLUSH:
  - opcode_i, cmp_flag_i and valid_i are ignored; they belong to squashed instructions. No nested branch is possible.
  - pc_sel_o = 0; nop_f_o = nop_d_o = 1; busy_o = 1.
  - Each cycle with stall_i=0: cnt decrements. When cnt==1 and stall_i=0, next state is IDLE and cnt <= 0.
- Stall:
  - stall_i=1 freezes the FSM and cnt.
  - In IDLE, a branch presented under stall is not taken (pc_sel_o=0) until stall_i drops. The opcode must still be present at that point (hazard unit holds the stage).
  - In FLUSH, the NOP strobes stay asserted while stalled.
- pc_hold_o = stall_i, in both states.
- busy_o = (state==FLUSH).
- Total NOP-strobe cycles per taken branch = FLUSH_DEPTH unstalled cycles, counted from and including the resolve cycle.
- Reset values: state=IDLE, cnt=0. Registered outputs are 0. Combinational outputs follow IDLE equations.
- Reset mid-flush: next cycle is IDLE with cnt=0; the flush is abandoned.
- Reset has priority over taken.

Optional Feature:
BRANCH_STATS_EN.
- Defined:
  - Adds output taken_cnt_o, 16 bits: count of taken branches/jumps.
  - Adds output flush_cyc_o, 16 bits: count of unstalled cycles with NOP strobes asserted.
  - Both reset to 0 on rst and saturate at 16'hFFFF.
- Undefined: no extra ports and no counter logic.

Decomposition:
- Shared package proc_pkg holds:
  - OPCODE_W and opcode constants OP_BR (4'b1110), OP_JMP (4'b1111).
  - FSM state encoding: ST_IDLE=1'b0, ST_FLUSH=1'b1.
- One sub-module, branch_decode: combinational taken/kind decode from valid_i, stall_i, opcode_i, cmp_flag_i.
- FSM, counter and optional stats counters stay in the top module.

Test Plan:
1. FLUSH_DEPTH=2; opcode 1110, cmp=1, valid=1, no stall -> pc_sel=1 and nop_f/nop_d=1 in cycle 0; nop=1, busy=1, pc_sel=0 in cycle 1; all 0 in cycle 2.
2. opcode 1110, cmp=0 -> pc_sel, nop and busy stay 0; opcode 1111, cmp=0 -> pc_sel=1, flush as in test 1.
3. Taken branch, then stall_i=1 for 3 cycles during FLUSH -> nop and busy held 1 for 3 extra cycles; pc_hold=1 while stalled; IDLE reached after 1 unstalled FLUSH cycle.
4. Branch presented with stall_i=1 -> pc_sel=0; stall drops -> pc_sel=1 that cycle.
5. FLUSH_DEPTH=4; rst asserted in second FLUSH cycle -> next cycle busy=0, nop=0; a new branch is then taken normally with a 4-cycle flush.
6. BRANCH_STATS_EN defined; 3 taken jumps with FLUSH_DEPTH=2 -> taken_cnt_o=3, flush_cyc_o=6; a branch in FLUSH is ignored, so taken_cnt_o does not increment.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the filter processor pipeline control blocks:
// opcode constants, branch FSM state encoding, decode result kinds and a
// saturating-counter helper used by the optional branch statistics
// (enabled with the BRANCH_STATS_EN macro in branch_flush_ctrl).
package proc_pkg;

  // Opcode field width and the two control-transfer opcodes.
  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_BR  = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b1111;

  // Branch resolution FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Result of the resolve-stage decode; anything but KIND_NONE redirects the PC.
  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_BR   = 2'b01,
    KIND_JMP  = 2'b10
  } kind_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// Resolve-stage interface of branch_flush_ctrl. The master side is the
// pipeline/hazard logic presenting the instruction; the slave side is the
// branch/flush controller returning PC and squash controls. The optional
// BRANCH_STATS_EN counters are plain ports on the controller, not here.
interface branch_flush_ctrl_if #(
  parameter int OPCODE_W = proc_pkg::OPCODE_W
);

  logic                valid_i;
  logic [OPCODE_W-1:0] opcode_i;
  logic                cmp_flag_i;
  logic                stall_i;
  logic                pc_sel_o;
  logic                pc_hold_o;
  logic                nop_f_o;
  logic                nop_d_o;
  logic                busy_o;

  modport master (
    output valid_i, opcode_i, cmp_flag_i, stall_i,
    input  pc_sel_o, pc_hold_o, nop_f_o, nop_d_o, busy_o
  );

  modport slave (
    input  valid_i, opcode_i, cmp_flag_i, stall_i,
    output pc_sel_o, pc_hold_o, nop_f_o, nop_d_o, busy_o
  );

endinterface

// File: rtl/branch_decode.sv
// Resolve-stage decode: classifies the presented instruction as a taken
// conditional branch, an unconditional jump, or nothing. A stalled or
// invalid slot never resolves, so the hazard unit can hold a branch in
// place until the stall drops. Used by branch_flush_ctrl.
module branch_decode
  import proc_pkg::*;
#(
  parameter int                  OPCODE_W   = proc_pkg::OPCODE_W,
  parameter logic [OPCODE_W-1:0] BR_OPCODE  = proc_pkg::OP_BR,
  parameter logic [OPCODE_W-1:0] JMP_OPCODE = proc_pkg::OP_JMP
) (
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_cmp_flag,
  output kind_t               o_kind
);

  kind_t w_kind;

  // Classify the instruction; only an unstalled valid slot can be taken.
  always_comb begin
    w_kind = KIND_NONE;
    if (i_valid && !i_stall) begin
      if (i_opcode == JMP_OPCODE) begin
        w_kind = KIND_JMP;
      end else if ((i_opcode == BR_OPCODE) && i_cmp_flag) begin
        w_kind = KIND_BR;
      end else begin
        w_kind = KIND_NONE;
      end
    end else begin
      w_kind = KIND_NONE;
    end
  end

  assign o_kind = w_kind;

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch/jump resolution unit. Selects the branch target into the PC in the
// resolve cycle and squashes the FLUSH_DEPTH younger instructions by holding
// the NOP-insert strobes for FLUSH_DEPTH unstalled cycles (resolve cycle
// included). Stalls freeze the flush and are forwarded as the PC hold.
// Optional feature: define BRANCH_STATS_EN to add the saturating 16-bit
// taken_cnt_o / flush_cyc_o statistics outputs.
module branch_flush_ctrl
  import proc_pkg::*;
#(
  parameter int                  OPCODE_W    = proc_pkg::OPCODE_W,
  parameter logic [OPCODE_W-1:0] BR_OPCODE   = proc_pkg::OP_BR,
  parameter logic [OPCODE_W-1:0] JMP_OPCODE  = proc_pkg::OP_JMP,
  parameter int                  FLUSH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  branch_flush_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]        taken_cnt_o,
  output logic [15:0]        flush_cyc_o
`endif
);

  // Counter width follows the depth; it holds the squash slots still owed.
  localparam int               CNT_W      = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FLUSH_DEPTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  kind_t            w_kind;
  logic             w_taken;
  logic             w_pc_sel;
  logic             w_nop;
  logic             w_busy;

  branch_decode #(
    .OPCODE_W   (OPCODE_W),
    .BR_OPCODE  (BR_OPCODE),
    .JMP_OPCODE (JMP_OPCODE)
  ) u_decode (
    .i_valid    (bus.valid_i),
    .i_stall    (bus.stall_i),
    .i_opcode   (bus.opcode_i),
    .i_cmp_flag (bus.cmp_flag_i),
    .o_kind     (w_kind)
  );

  assign w_taken = (w_kind != KIND_NONE);

  // State and flush-counter register; reset abandons any flush in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_CNT_ZERO;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state and counter update; a stall freezes both.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_taken) begin
          // A depth of one is fully covered by the resolve-cycle strobe.
          if (FLUSH_DEPTH > 1) begin
            w_next_state = ST_FLUSH;
            w_next_cnt   = C_CNT_LOAD;
          end else begin
            w_next_state = ST_IDLE;
            w_next_cnt   = C_CNT_ZERO;
          end
        end else begin
          w_next_state = ST_IDLE;
          w_next_cnt   = r_cnt;
        end
      end
      ST_FLUSH: begin
        // The resolve-stage inputs belong to squashed instructions here.
        if (!bus.stall_i) begin
          if (r_cnt == C_CNT_ONE) begin
            w_next_state = ST_IDLE;
            w_next_cnt   = C_CNT_ZERO;
          end else begin
            w_next_state = ST_FLUSH;
            w_next_cnt   = r_cnt - C_CNT_ONE;
          end
        end else begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = r_cnt;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = C_CNT_ZERO;
      end
    endcase
  end

  // Output decode: redirect and squash in the resolve cycle, squash only while flushing.
  always_comb begin
    w_pc_sel = 1'b0;
    w_nop    = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pc_sel = w_taken;
        w_nop    = w_taken;
        w_busy   = 1'b0;
      end
      ST_FLUSH: begin
        w_pc_sel = 1'b0;
        w_nop    = 1'b1;
        w_busy   = 1'b1;
      end
      default: begin
        w_pc_sel = 1'b0;
        w_nop    = 1'b0;
        w_busy   = 1'b0;
      end
    endcase
  end

  assign bus.pc_sel_o  = w_pc_sel;
  assign bus.nop_f_o   = w_nop;
  assign bus.nop_d_o   = w_nop;
  assign bus.busy_o    = w_busy;
  assign bus.pc_hold_o = bus.stall_i;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_flush_cyc;
  logic        w_accept;
  logic        w_flush_cyc;

  // Only an IDLE-state resolve is accepted; strobes only count when the pipe moves.
  assign w_accept    = (r_state == ST_IDLE) && w_taken;
  assign w_flush_cyc = w_nop && !bus.stall_i;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken_cnt <= 16'd0;
      r_flush_cyc <= 16'd0;
    end else begin
      if (w_accept) begin
        r_taken_cnt <= sat_inc16(r_taken_cnt);
      end else begin
        r_taken_cnt <= r_taken_cnt;
      end
      if (w_flush_cyc) begin
        r_flush_cyc <= sat_inc16(r_flush_cyc);
      end else begin
        r_flush_cyc <= r_flush_cyc;
      end
    end
  end

  assign taken_cnt_o = r_taken_cnt;
  assign flush_cyc_o = r_flush_cyc;
`endif

endmodule
